// File: rtl/arbitro_escrita_br.sv
// Register-file write-port arbiter between the ULA and MEM producers.
// Each producer has a one-entry holding register. A round-robin grant drives a registered write strobe, and a RAW scoreboard tracks pending writes.
module arbitro_escrita_br #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ula_valido,
    input  logic [ADDR_W-1:0]   ula_endereco,
    input  logic [DATA_W-1:0]   ula_dado,
    output logic                ula_pronto,
    input  logic                mem_valido,
    input  logic [ADDR_W-1:0]   mem_endereco,
    input  logic [DATA_W-1:0]   mem_dado,
    output logic                mem_pronto,
    input  logic                reserva_valido,
    input  logic [ADDR_W-1:0]   reserva_endereco,
    output logic [NUM_REGS-1:0] pendentes,
    output logic                br_escrita,
    output logic [ADDR_W-1:0]   br_endereco,
    output logic [DATA_W-1:0]   br_dado
);

    typedef enum logic {ULTIMO_ULA, ULTIMO_MEM} ultimo_t;

    ultimo_t             ultimo;
    logic                ula_cheio, mem_cheio;
    logic [ADDR_W-1:0]   ula_end_h, mem_end_h;
    logic [DATA_W-1:0]   ula_dado_h, mem_dado_h;

    logic                conc_ula, conc_mem, escreve;
    logic [ADDR_W-1:0]   end_conc;
    logic [DATA_W-1:0]   dado_conc;
    logic [NUM_REGS-1:0] marca, limpa, pend_prox;

    assign ula_pronto = !ula_cheio;
    assign mem_pronto = !mem_cheio;

    always_comb begin
        conc_ula  = ula_cheio && (!mem_cheio || ultimo == ULTIMO_MEM);
        conc_mem  = mem_cheio && !conc_ula;
        end_conc  = conc_mem ? mem_end_h  : ula_end_h;
        dado_conc = conc_mem ? mem_dado_h : ula_dado_h;
        escreve   = (conc_ula || conc_mem) && (end_conc != '0);
        marca     = '0;
        limpa     = '0;
        if (reserva_valido && reserva_endereco != '0)
            marca[reserva_endereco] = 1'b1;
        if (escreve)
            limpa[end_conc] = 1'b1;
        // A reservation on the issuing edge is newer than the write, so set wins over clear.
        pend_prox = (pendentes & ~limpa) | marca;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ultimo      <= ULTIMO_MEM;
            ula_cheio   <= 1'b0;
            mem_cheio   <= 1'b0;
            ula_end_h   <= '0;
            mem_end_h   <= '0;
            ula_dado_h  <= '0;
            mem_dado_h  <= '0;
            pendentes   <= '0;
            br_escrita  <= 1'b0;
            br_endereco <= '0;
            br_dado     <= '0;
        end else begin
            br_escrita <= escreve;
            if (escreve) begin
                br_endereco <= end_conc;
                br_dado     <= dado_conc;
            end
            if (conc_ula) begin
                ula_cheio <= 1'b0;
                ultimo    <= ULTIMO_ULA;
            end
            if (conc_mem) begin
                mem_cheio <= 1'b0;
                ultimo    <= ULTIMO_MEM;
            end
            // Accept only into a slot empty at the start of the cycle (no bypass).
            if (ula_valido && !ula_cheio) begin
                ula_cheio  <= 1'b1;
                ula_end_h  <= ula_endereco;
                ula_dado_h <= ula_dado;
            end
            if (mem_valido && !mem_cheio) begin
                mem_cheio  <= 1'b1;
                mem_end_h  <= mem_endereco;
                mem_dado_h <= mem_dado;
            end
            pendentes <= pend_prox;
        end
    end

endmodule

// File: tb/tb_arbitro_escrita_br.sv
// Bench for arbitro_escrita_br: directed scenarios followed by random traffic.
// Every cycle is checked against a transaction-level reference model.
module tb_arbitro_escrita_br;

    logic        clock = 1'b0;
    logic        reset;
    logic        ula_valido, mem_valido, reserva_valido;
    logic [4:0]  ula_endereco, mem_endereco, reserva_endereco;
    logic [31:0] ula_dado, mem_dado;
    logic        ula_pronto, mem_pronto, br_escrita;
    logic [31:0] pendentes;
    logic [4:0]  br_endereco;
    logic [31:0] br_dado;

    int checks = 0;
    int fails  = 0;

    // Reference model state: slot 0 = ULA, slot 1 = MEM; turn = slot favoured on contention.
    bit          m_full [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    int          m_turn;
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    arbitro_escrita_br #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clock(clock), .reset(reset),
        .ula_valido(ula_valido), .ula_endereco(ula_endereco), .ula_dado(ula_dado), .ula_pronto(ula_pronto),
        .mem_valido(mem_valido), .mem_endereco(mem_endereco), .mem_dado(mem_dado), .mem_pronto(mem_pronto),
        .reserva_valido(reserva_valido), .reserva_endereco(reserva_endereco), .pendentes(pendentes),
        .br_escrita(br_escrita), .br_endereco(br_endereco), .br_dado(br_dado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare all outputs.
    task automatic tick(input logic rst,
                        input logic uv, input logic [4:0] ua, input logic [31:0] ud,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic rv, input logic [4:0] ra);
        int g;
        bit acc [2];
        logic [31:0] clr, set;
        reset = rst;
        ula_valido = uv; ula_endereco = ua; ula_dado = ud;
        mem_valido = mv; mem_endereco = ma; mem_dado = md;
        reserva_valido = rv; reserva_endereco = ra;
        acc[0] = uv && !m_full[0];
        acc[1] = mv && !m_full[1];
        @(posedge clock);
        if (rst) begin
            m_full[0] = 0; m_full[1] = 0; m_turn = 0;
            m_pend = '0; m_we = 0; m_wa = '0; m_wd = '0;
        end else begin
            g = -1;
            if (m_full[0] && m_full[1]) g = m_turn;
            else if (m_full[0]) g = 0;
            else if (m_full[1]) g = 1;
            m_we = 0;
            clr = '0;
            if (g >= 0) begin
                if (m_addr[g] != 0) begin
                    m_we = 1; m_wa = m_addr[g]; m_wd = m_data[g];
                    clr = 32'd1 << m_addr[g];
                end
                m_full[g] = 0;
                m_turn = 1 - g;
            end
            if (acc[0]) begin m_full[0] = 1; m_addr[0] = ua; m_data[0] = ud; end
            if (acc[1]) begin m_full[1] = 1; m_addr[1] = ma; m_data[1] = md; end
            set = (rv && ra != 0) ? (32'd1 << ra) : 32'd0;
            m_pend = (m_pend & ~clr) | set;
        end
        #1;
        chk("ula_pronto", {31'd0, ula_pronto}, {31'd0, !m_full[0]});
        chk("mem_pronto", {31'd0, mem_pronto}, {31'd0, !m_full[1]});
        chk("br_escrita", {31'd0, br_escrita}, {31'd0, m_we});
        chk("br_endereco", {27'd0, br_endereco}, {27'd0, m_wa});
        chk("br_dado", br_dado, m_wd);
        chk("pendentes", pendentes, m_pend);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_turn = 0; m_pend = '0;
        m_full[0] = 0; m_full[1] = 0;
        @(negedge clock);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // 1: lone ULA write, pulse on second cycle after accept edge
        tick(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("t1_ula_busy", {31'd0, ula_pronto}, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_pulse", {31'd0, br_escrita}, 32'd1);
        chk("t1_addr", {27'd0, br_endereco}, 32'd5);
        chk("t1_data", br_dado, 32'hDEADBEEF);
        idle(2);

        // 2: simultaneous requests alternate by last grant
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 5'd1, 32'd1, 1, 5'd2, 32'd2, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_first", {27'd0, br_endereco}, 32'd1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_second", {27'd0, br_endereco}, 32'd2);
        tick(0, 1, 5'd3, 32'd3, 1, 5'd4, 32'd4, 0, 0);
        idle(3);

        // 3: MEM write to r0 produces no strobe
        tick(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_no_pulse", {31'd0, br_escrita}, 32'd0);
        chk("t3_mem_free", {31'd0, mem_pronto}, 32'd1);
        idle(1);

        // 4: reserve r7, write r7, then re-reserve on the issuing edge
        tick(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
        tick(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_cleared", pendentes, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
        tick(0, 1, 5'd7, 32'h78, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
        chk("t4_newer_wins", pendentes, 32'h80);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5: reserve r0 has no effect; double reservation cleared by one write
        tick(0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 5'd3);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 5'd3);
        tick(0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0);
        idle(2);

        // 6: reset with both slots full drops held writes
        for (int unsigned r = 4; r < 8; r++) tick(0, 0, 0, 0, 0, 0, 0, 1, r[4:0]);
        tick(0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, 0, 0);
        chk("t6_pend", pendentes, 32'h000000F0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_pend_rst", pendentes, 32'd0);
        idle(3);

        // random traffic on a small address range to provoke hazards
        for (int unsigned i = 0; i < 600; i++) begin
            tick(($urandom % 64) == 0,
                 $urandom % 2, 5'($urandom % 8), $urandom,
                 $urandom % 2, 5'($urandom % 8), $urandom,
                 $urandom % 2, 5'($urandom % 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
